// File: rtl/order_25d_pkg.sv
// Shared constants, tag type and rank clamp for the 25-element order-statistic scheduler.
package order_25d_pkg;

  localparam int unsigned N_ELEM      = 25;
  localparam int unsigned RANK_W      = 5;
  localparam int unsigned MEDIAN_RANK = 12;
  localparam int unsigned RANK_MAX    = 24;

  typedef struct packed {
    logic              vld;
    logic [RANK_W-1:0] rank;
    logic              last;
  } tag_t;

  function automatic logic [RANK_W-1:0] clamp_rank(input logic [RANK_W-1:0] rank);
    return (rank > RANK_W'(RANK_MAX)) ? RANK_W'(RANK_MAX) : rank;
  endfunction

endpackage

// File: rtl/order_25d_res_fifo.sv
// Result FIFO for order_25d_sched: synchronous, async active-low reset, MSB-wrap pointers.
module order_25d_res_fifo #(
  parameter int unsigned WIDTH = 65,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             wr_en, rd_en;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign wr_en = wr && !full;
  assign rd_en = rd && !empty;
  // Head is forced to zero when empty so the output is defined out of reset.
  assign rdata = empty ? '0 : mem[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr_q[AW-1:0]] <= wdata;
  end

  write_while_full: assert property (@(posedge clock) disable iff (!rst_n) !(wr && full));

endmodule

// File: rtl/order_25d_sched.sv
// Valid/ready front end, tag pipe and credit-throttled result FIFO for the 25-element sort net.
// Optional statistics counters are built when ORDER_25D_SCHED_STAT_EN is defined.
module order_25d_sched
  import order_25d_pkg::*;
#(
  parameter int unsigned DSIZE      = 64,
  parameter int unsigned SORT_LAT   = 6,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                    clock,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [RANK_W-1:0]       in_rank,
  input  logic                    in_last,
  input  logic [N_ELEM*DSIZE-1:0] sort_d,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DSIZE-1:0]        out_data,
  output logic                    out_last
`ifdef ORDER_25D_SCHED_STAT_EN
  ,
  output logic [31:0]             stat_acc_cnt,
  output logic [31:0]             stat_stall_cnt
`endif
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + SORT_LAT + 1);

  tag_t             pipe_q [SORT_LAT];
  tag_t             tag_in, tag_out;
  logic             accept, capture, push, pop;
  logic             fifo_full, fifo_empty;
  logic [CntW-1:0]  inflight_q, inflight_d, occ_q, occ_d;
  logic [CntW:0]    outstanding;
  logic [DSIZE-1:0] sel_data;

  // Credits come from registered counters only, so in_ready never depends on in_valid/out_ready.
  assign outstanding = {1'b0, occ_q} + {1'b0, inflight_q};
  assign in_ready    = outstanding < (CntW+1)'(FIFO_DEPTH);
  assign accept      = in_valid && in_ready;
  assign tag_out     = pipe_q[SORT_LAT-1];
  assign capture     = tag_out.vld;
  assign push        = capture && !fifo_full;
  assign out_valid   = !fifo_empty;
  assign pop         = out_valid && out_ready;
  assign sel_data    = sort_d[int'(tag_out.rank) * DSIZE +: DSIZE];

  always_comb begin
    tag_in = '0;
    if (accept) begin
      tag_in.vld  = 1'b1;
      tag_in.rank = clamp_rank(in_rank);
      tag_in.last = in_last;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(SORT_LAT); i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= tag_in;
      for (int i = 1; i < int'(SORT_LAT); i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  always_comb begin
    inflight_d = inflight_q + CntW'(accept) - CntW'(capture);
    occ_d      = occ_q + CntW'(push) - CntW'(pop);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= '0;
      occ_q      <= '0;
    end else begin
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
    end
  end

  order_25d_res_fifo #(
    .WIDTH (DSIZE + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_res_fifo (
    .clock (clock),
    .rst_n (rst_n),
    .wr    (capture),
    .wdata ({tag_out.last, sel_data}),
    .rd    (pop),
    .rdata ({out_last, out_data}),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef ORDER_25D_SCHED_STAT_EN
  logic [31:0] stat_acc_q, stat_stall_q;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      stat_acc_q   <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_acc_q   <= stat_acc_q + 32'(accept);
      stat_stall_q <= stat_stall_q + 32'(in_valid && !in_ready);
    end
  end

  assign stat_acc_cnt   = stat_acc_q;
  assign stat_stall_cnt = stat_stall_q;
`endif

endmodule

// File: tb/tb_order_25d_sched.sv
// Randomized self-checking bench for order_25d_sched against a queue-based reference model.
module tb_order_25d_sched;

  localparam int unsigned DSIZE      = 8;
  localparam int unsigned SORT_LAT   = 6;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned NE         = 25;

  logic                  clock, rst_n;
  logic                  in_valid, in_ready, in_last;
  logic [4:0]            in_rank;
  logic [NE*DSIZE-1:0]   sort_d;
  logic                  out_valid, out_ready, out_last;
  logic [DSIZE-1:0]      out_data;
`ifdef ORDER_25D_SCHED_STAT_EN
  logic [31:0]           stat_acc_cnt, stat_stall_cnt;
`endif

  order_25d_sched #(
    .DSIZE      (DSIZE),
    .SORT_LAT   (SORT_LAT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clock          (clock),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_rank        (in_rank),
    .in_last        (in_last),
    .sort_d         (sort_d),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_last       (out_last)
`ifdef ORDER_25D_SCHED_STAT_EN
    ,
    .stat_acc_cnt   (stat_acc_cnt),
    .stat_stall_cnt (stat_stall_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Stand-in sort network: a window with base b yields rank r = b + r, SORT_LAT edges later.
  logic [DSIZE-1:0] win_base;
  logic [DSIZE-1:0] net [SORT_LAT];

  always @(posedge clock) begin
    net[0] <= win_base;
    for (int i = 1; i < int'(SORT_LAT); i++) net[i] <= net[i-1];
  end

  always_comb begin
    sort_d = '0;
    for (int r = 0; r < int'(NE); r++) sort_d[r*DSIZE +: DSIZE] = net[SORT_LAT-1] + 8'(r);
  end

  typedef struct {
    logic [DSIZE-1:0] val;
    logic             last;
    int unsigned      acc_edge;
  } exp_t;

  exp_t        q[$];
  int unsigned edge_cnt, n_checks, n_fail;
  int unsigned mdl_acc, mdl_stall, out_idx, win_idx, dut_acc;
  logic        pos_chk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, edge_cnt);
    end
  endtask

  // Called just after a negedge with inputs set; checks outputs, advances one edge.
  task automatic cycle();
    logic       exp_ready, exp_valid, acc, pop;
    logic [4:0] rk;
    exp_t       e;
    exp_ready = q.size() < FIFO_DEPTH;
    exp_valid = (q.size() != 0) && (q[0].acc_edge + SORT_LAT <= edge_cnt);
    check_eq("in_ready", in_ready, exp_ready);
    check_eq("out_valid", out_valid, exp_valid);
    if (exp_valid) begin
      check_eq("out_data", out_data, q[0].val);
      check_eq("out_last", out_last, q[0].last);
      if (pos_chk && out_ready) check_eq("last_pos", out_last, (out_idx % 5) == 4);
    end
`ifdef ORDER_25D_SCHED_STAT_EN
    check_eq("stat_acc", stat_acc_cnt, mdl_acc);
    check_eq("stat_stall", stat_stall_cnt, mdl_stall);
`endif
    if (in_valid && in_ready) dut_acc++;
    acc = in_valid && exp_ready;
    pop = exp_valid && out_ready;
    rk  = (in_rank > 5'd24) ? 5'd24 : in_rank;
    e.val  = win_base + 8'(rk);
    e.last = in_last;
    @(posedge clock);
    edge_cnt++;
    if (pop) begin
      void'(q.pop_front());
      out_idx++;
    end
    if (acc) begin
      e.acc_edge = edge_cnt;
      q.push_back(e);
      mdl_acc++;
      win_idx++;
    end
    if (in_valid && !exp_ready) mdl_stall++;
    @(negedge clock);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40 && q.size() != 0; i++) cycle();
    check_eq("drained", q.size(), 0);
  endtask

  task automatic drive(input logic v, input logic [4:0] rank, input logic [7:0] base);
    in_valid = v;
    in_rank  = rank;
    win_base = base;
    cycle();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_rank = '0; in_last = 1'b0;
    out_ready = 1'b0; win_base = '0; pos_chk = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_eq("rst_in_ready", in_ready, 1'b1);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_out_last", out_last, 1'b0);
    rst_n = 1'b1;

    // Median sweep: back-to-back windows, every output 22
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) drive(1'b1, 5'd12, 8'd10);
    drain();

    // Rank clamp
    for (int i = 0; i < 8; i++)
      drive(1'b1, (i == 0) ? 5'd31 : 5'($urandom_range(25, 31)), 8'd10);
    drain();

    // Backpressure: exactly FIFO_DEPTH accepts, then stall
    out_ready = 1'b0;
    dut_acc   = 0;
    for (int i = 0; i < 20; i++) drive(1'b1, 5'($urandom_range(0, 31)), 8'($urandom_range(0, 200)));
    check_eq("bp_accepts", dut_acc, FIFO_DEPTH);
    drain();

    // Accept, push and pop together with FIFO_DEPTH-1 outstanding
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) drive(1'b1, 5'($urandom_range(0, 24)), 8'($urandom_range(0, 200)));
    for (int i = 0; i < 5; i++) drive(1'b0, 5'd0, 8'd0);
    drive(1'b1, 5'd3, 8'd77);
    for (int i = 0; i < 5; i++) drive(1'b0, 5'd0, 8'd0);
    out_ready = 1'b1;
    drive(1'b1, 5'd20, 8'd100);
    drive(1'b0, 5'd0, 8'd0);
    drain();

    // Random traffic with a last tag on every 5th window
    out_idx = 0;
    win_idx = 0;
    pos_chk = 1'b1;
    for (int i = 0; i < 300; i++) begin
      out_ready = ($urandom_range(0, 1) == 1);
      in_last   = (win_idx % 5) == 4;
      drive($urandom_range(0, 9) < 7, 5'($urandom_range(0, 31)), 8'($urandom_range(0, 200)));
    end
    in_last = (win_idx % 5) == 4;
    drain();
    pos_chk = 1'b0;
    in_last = 1'b0;

    // Reset with 4 windows in the pipe and 3 results in the FIFO
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) drive(1'b1, 5'd12, 8'($urandom_range(0, 200)));
    for (int i = 0; i < 3; i++) drive(1'b0, 5'd0, 8'd0);
    for (int i = 0; i < 4; i++) drive(1'b1, 5'd12, 8'($urandom_range(0, 200)));
    check_eq("pre_rst_out_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_out_valid", out_valid, 1'b0);
    check_eq("mid_rst_in_ready", in_ready, 1'b1);
    check_eq("mid_rst_out_data", out_data, 0);
    q.delete();
    mdl_acc   = 0;
    mdl_stall = 0;
    @(posedge clock);
    @(negedge clock);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < int'(SORT_LAT) + 2; i++) drive(1'b0, 5'd0, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
